// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard unit: RAW/load-use stalls, data-memory wait, control-transfer flush and HALT.
// Build with HZU_FORWARDING_EN defined for a forwarding datapath; only load-use then stalls.
module pipeline_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic [REGW-1:0] ex_rd,
    input  logic [REGW-1:0] mem_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic            mem_regwrite,
    input  logic            branch_taken,
    input  logic            jump,
    input  logic            dmemREN,
    input  logic            dmemWEN,
    input  logic            dhit,
    input  logic            halt,
    output logic            stall_ifid,
    output logic            stall_idex,
    output logic            stall_xmem,
    output logic            stall_wb,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            flush_xmem,
    output logic            flush_wb,
    output logic            pc_en,
    output logic [2:0]      hz_state,
    output logic [CNTW-1:0] stall_cycles
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DMEM_WAIT = 3'd1,
        RAW_STALL = 3'd2,
        HALT      = 3'd3
    } hz_state_t;

    hz_state_t       state_q, state_d;
    logic [1:0]      raw_cnt_q, raw_cnt_d;
    logic [CNTW-1:0] stall_cycles_q;

    logic       dmem_pend;
    logic       ctrl_xfer;
    logic       raw_hit;
    logic [1:0] raw_load;
    logic       unused_inputs;

    function automatic logic src_match(input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                                       input logic uses_rt, input logic [REGW-1:0] rd);
        return ((rs != '0) && (rs == rd)) || (uses_rt && (rt != '0) && (rt == rd));
    endfunction

    assign dmem_pend = (dmemREN | dmemWEN) & ~dhit;
    assign ctrl_xfer = branch_taken | jump;

`ifdef HZU_FORWARDING_EN
    assign raw_hit       = ex_memread && src_match(id_rs, id_rt, id_uses_rt, ex_rd);
    assign raw_load      = 2'd0;
    assign unused_inputs = ^{ex_regwrite, mem_regwrite, mem_rd};
`else
    // An EX producer needs one more bubble than a MEM producer, so it takes precedence.
    logic ex_hit, mem_hit;
    assign ex_hit        = ex_regwrite && src_match(id_rs, id_rt, id_uses_rt, ex_rd);
    assign mem_hit       = mem_regwrite && src_match(id_rs, id_rt, id_uses_rt, mem_rd);
    assign raw_hit       = ex_hit | mem_hit;
    assign raw_load      = ex_hit ? 2'd1 : 2'd0;
    assign unused_inputs = ex_memread;
`endif

    always_comb begin
        state_d    = state_q;
        raw_cnt_d  = raw_cnt_q;
        stall_ifid = 1'b0;
        stall_idex = 1'b0;
        stall_xmem = 1'b0;
        stall_wb   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        flush_xmem = 1'b0;
        flush_wb   = 1'b0;
        pc_en      = 1'b1;
        if (state_q == HALT || halt || dmem_pend) begin
            stall_ifid = 1'b1;
            stall_idex = 1'b1;
            stall_xmem = 1'b1;
            stall_wb   = 1'b1;
            pc_en      = 1'b0;
            if (state_q != HALT)
                state_d = halt ? HALT : DMEM_WAIT;
        end else if (ctrl_xfer) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            raw_cnt_d  = 2'd0;
            state_d    = RUN;
        end else begin
            case (state_q)
                DMEM_WAIT: state_d = (raw_cnt_q != 2'd0) ? RAW_STALL : RUN;
                RAW_STALL: begin
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_en      = 1'b0;
                    raw_cnt_d  = (raw_cnt_q != 2'd0) ? raw_cnt_q - 2'd1 : 2'd0;
                    state_d    = (raw_cnt_q <= 2'd1) ? RUN : RAW_STALL;
                end
                default: begin
                    state_d = RUN;
                    if (raw_hit) begin
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        pc_en      = 1'b0;
                        raw_cnt_d  = raw_load;
                        state_d    = (raw_load != 2'd0) ? RAW_STALL : RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q        <= RUN;
            raw_cnt_q      <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q   <= state_d;
            raw_cnt_q <= raw_cnt_d;
            if (!pc_en && state_q != HALT && stall_cycles_q != '1)
                stall_cycles_q <= stall_cycles_q + 1'b1;
        end
    end

    assign hz_state     = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule
